// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// the newline byte that ends a line lock, and the grant index width helper.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_LOCK = 2'd2
  } arb_state_e;

  localparam logic [7:0] UART_NEWLINE = 8'h0A;

  // Width of an index into n requesters, never less than one bit.
  function automatic int arb_id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first eligible request at or after
// start, scanning upward and wrapping; eligible means req & mask.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] eligible;

  assign eligible = req & mask;

  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(start) + i) % N;
      if (!any && eligible[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// producers. Define UART_ARB_LINE_LOCK_EN to hold the grant until a newline.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IW = arb_id_width(NUM_REQ);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] SEND = ST_SEND;
  localparam logic [1:0] LOCK = ST_LOCK;

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 2..16");
  end
  if (LOCK_TIMEOUT < 1) begin : g_bad_lock_timeout
    $error("uart_tx_arbiter: LOCK_TIMEOUT must be at least 1");
  end

  logic [1:0]         state;
  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] pick_mask;
  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [7:0]         pick_byte;
  logic [IW-1:0]      next_ptr;

`ifdef UART_ARB_LINE_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] lock_cnt;
`endif

  // Handshakes are strict valid/ready: a byte moves on a clock edge only when
  // valid and ready are both high; valid never depends on ready, and a
  // producer holds valid and data stable until its own ready is seen.

  assign owner_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

  always_comb begin
    pick_mask = '0;
    case (state)
      IDLE:    pick_mask = '1;
      LOCK:    pick_mask = owner_mask;
      default: pick_mask = '0;
    endcase
  end

  uart_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .start (rr_ptr),
    .mask  (pick_mask),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready = reset ? '0 : pick_gnt;
  assign pick_byte = req_data[{pick_idx, 3'b000} +: 8];
  assign next_ptr  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= '0;
      rr_ptr   <= '0;
`ifdef UART_ARB_LINE_LOCK_EN
      lock_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            tx_data  <= pick_byte;
            grant_id <= pick_idx;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            rr_ptr   <= next_ptr;
`ifdef UART_ARB_LINE_LOCK_EN
            if (tx_data == UART_NEWLINE) begin
              state <= IDLE;
            end else begin
              state    <= LOCK;
              lock_cnt <= '0;
            end
`else
            state <= IDLE;
`endif
          end
        end
`ifdef UART_ARB_LINE_LOCK_EN
        LOCK: begin
          // The owner is the only eligible requester here, so pick_idx == grant_id.
          if (pick_any) begin
            tx_data  <= pick_byte;
            tx_valid <= 1'b1;
            state    <= SEND;
          end else if (lock_cnt == CW'(LOCK_TIMEOUT - 1)) begin
            state <= IDLE;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the SoC's single UART transmitter between `NUM_REQ` byte producers, typically one per hardware thread of the interleaved-multithreading core plus a debug source. It sits between the requesters and the transmitter's byte-input handshake. It picks producers round-robin and registers the chosen byte toward the transmitter. It can optionally hold the grant for a whole text line, so that console output from different threads never interleaves mid-line.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters. Range 2..16.
- `LOCK_TIMEOUT`, default 4096: idle cycles before a line lock is dropped. Must be at least 1. Used only when line lock is compiled in.

Ports:
- `clk`, input, 1 bit: the single clock.
- `reset`, input, 1 bit: synchronous, active-high.
- `req_valid`, input, `NUM_REQ` bits: requester i has a byte pending.
- `req_data`, input, `8*NUM_REQ` bits: requester i's byte is bits [8i+7:8i].
- `req_ready`, output, `NUM_REQ` bits: one-hot accept. A byte transfers when `req_valid[i] & req_ready[i]`.
- `tx_valid`, output, 1 bit: a byte is offered to the transmitter.
- `tx_data`, output, 8 bits: the offered byte.
- `tx_ready`, input, 1 bit: the transmitter takes the byte when `tx_valid & tx_ready`.
- `grant_id`, output, `$clog2(NUM_REQ)` bits: index of the last or current owner.
- `busy`, output, 1 bit: high in any state other than IDLE.

## Operation

States:
- **IDLE**
  - The pick starts at `rr_ptr`, the index after the previous winner, wrapping from `NUM_REQ-1` to 0, and scans upward.
  - The first requester found with `req_valid` high gets `req_ready` high combinationally in that cycle.
  - On that cycle the arbiter latches `tx_data`, sets `grant_id`, and goes to SEND.
- **SEND**
  - `tx_valid` is high and `tx_data` is held stable.
  - On `tx_ready`, `tx_valid` drops on the next edge and `rr_ptr` becomes `grant_id+1` (mod `NUM_REQ`).
  - The next state is LOCK or IDLE, as described under Configuration.
- **LOCK**
  - Only requester `grant_id` may receive `req_ready`. Its handshake latches the byte and goes to SEND.
  - A timeout counter clears on entry and increments every cycle with no owner handshake.
  - When the counter reaches `LOCK_TIMEOUT`, the state returns to IDLE.

Rules:
- `req_ready` is all zeros in SEND, so at most one bit is ever set.
- Requesters must hold `req_valid` and their data until the handshake. A withdrawn request has no effect.
- `tx_ready` while `tx_valid` is low is ignored.
- In IDLE, when several requesters are valid at once, the winner is strictly the first at or after `rr_ptr`.

## Timing

- Reset values: `tx_valid` 0, `tx_data` 8'h00, `req_ready` 0, `grant_id` 0, `busy` 0. `rr_ptr` and the timeout counter reset to 0.
- Latency: a request handshake in cycle n gives `tx_valid` high in cycle n+1.
- Throughput: a `tx_ready` in cycle m allows the next request handshake in cycle m+1. Peak rate is one byte per 2 cycles.
- Reset during SEND discards the held byte. `tx_valid` is 0 in the cycle after reset is sampled.
- Reset has priority over every transition.

## Configuration

- Macro `UART_ARB_LINE_LOCK_EN`.
- **Defined:** after SEND completes, a byte equal to 8'h0A (newline) goes to IDLE; any other byte goes to LOCK.
- **Undefined:** SEND always returns to IDLE, giving per-byte round-robin. The LOCK state, timeout counter and `LOCK_TIMEOUT` logic are not synthesized.

## Structure

- Shared package `uart_arb_pkg`:
  - state enum (IDLE, SEND, LOCK);
  - `UART_NEWLINE` = 8'h0A;
  - a width helper for `grant_id`.
- One sub-module, `uart_rr_pick`: combinational round-robin picker.
  - Inputs: request vector, start pointer, mask.
  - Outputs: one-hot grant, index, and an any-request flag.

## Test plan

- **Reset:** hold `reset` for 3 cycles with all `req_valid` high. All outputs must stay 0. In the first cycle after release, `req_ready` must be 4'b0001.
- **Contention, no lock:** all 4 requesters send 'A','B','C','D' continuously, `tx_ready`=1. `tx_data` must cycle A,B,C,D,A, with `tx_valid` high every second cycle.
- **Backpressure:** hold `tx_ready`=0 for 20 cycles. `tx_valid` stays high with the byte unchanged, and `req_ready` stays 0. Exactly one transfer occurs when `tx_ready` rises.
- **Line lock:** with the macro defined, requester 2 sends "hi\n" while requester 0 is valid. `tx_data` must be 'h','i',8'h0A, then requester 0's byte.
- **Lock timeout:** `LOCK_TIMEOUT`=8. Requester 1 sends 'x' and then goes idle while requester 3 is valid. Requester 3 must be granted exactly 8 cycles after LOCK is entered.
- **Reset mid-SEND:** with `tx_valid` high, assert `reset`. `tx_valid` must be 0 on the next cycle, and the discarded byte must never appear at the transmitter.
